// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// load/store data, with round-robin tie-breaking and fixed memory latency.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_W-1:0]     if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_W-1:0]     d_addr_i,
  input  logic [DATA_W-1:0]     d_wdata_i,
  input  logic [DATA_W/8-1:0]   d_be_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_W-1:0]     d_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0] LP_CNT_INIT = 3'(MEM_LAT - 1);

  state_t              r_state;
  logic [2:0]          r_cnt;
  logic                r_last_d;
  logic                r_owner_d;
  logic                r_owner_we;
  logic                r_if_rvalid;
  logic                r_d_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  logic                w_open;
  logic                w_if_gnt;
  logic                w_d_gnt;

  // Grants are gated by reset so every output reads 0 while rst_i is high.
  always_comb begin
    w_open   = (r_state != WAIT) && !rst_i;
    w_if_gnt = w_open && if_req_i && (!d_req_i || r_last_d);
    w_d_gnt  = w_open && d_req_i && !w_if_gnt;

    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (w_if_gnt) begin
      mem_en_o   = 1'b1;
      mem_addr_o = if_addr_i;
    end else if (w_d_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_be_o    = d_be_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last_d    <= 1'b1;
      r_owner_d   <= 1'b0;
      r_owner_we  <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      case (r_state)
        IDLE, RESP: begin
          if (w_if_gnt || w_d_gnt) begin
            r_state    <= WAIT;
            r_cnt      <= LP_CNT_INIT;
            r_last_d   <= w_d_gnt;
            r_owner_d  <= w_d_gnt;
            r_owner_we <= w_d_gnt && d_we_i;
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state <= RESP;
            if (r_owner_d) begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= r_owner_we ? '0 : mem_rdata_i;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= mem_rdata_i;
            end
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_gnt_o    = w_if_gnt;
  assign d_gnt_o     = w_d_gnt;
  assign if_rvalid_o = r_if_rvalid;
  assign d_rvalid_o  = r_d_rvalid;
  assign if_rdata_o  = r_if_rdata;
  assign d_rdata_o   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: four instances (MEM_LAT 1,2,4,8)
// share one stimulus set; each step checks the instance under test.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        use_fixed;
  logic [31:0] fixed_val;
  logic [15:0] cyc = '0;
  logic [31:0] mem_rdata;

  logic        if_gnt    [4];
  logic        if_rvalid [4];
  logic [31:0] if_rdata  [4];
  logic        d_gnt     [4];
  logic        d_rvalid  [4];
  logic [31:0] d_rdata   [4];
  logic        mem_en    [4];
  logic        mem_we    [4];
  logic [31:0] mem_addr  [4];
  logic [31:0] mem_wdata [4];
  logic [3:0]  mem_be    [4];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  function automatic logic [31:0] pat(input logic [15:0] c);
    return {16'hC0DE, c};
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;
  assign mem_rdata = use_fixed ? fixed_val : pat(cyc);

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .MEM_LAT(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 4 : 8)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .if_req_i   (if_req),
      .if_addr_i  (if_addr),
      .if_gnt_o   (if_gnt[g]),
      .if_rvalid_o(if_rvalid[g]),
      .if_rdata_o (if_rdata[g]),
      .d_req_i    (d_req),
      .d_we_i     (d_we),
      .d_addr_i   (d_addr),
      .d_wdata_i  (d_wdata),
      .d_be_i     (d_be),
      .d_gnt_o    (d_gnt[g]),
      .d_rvalid_o (d_rvalid[g]),
      .d_rdata_o  (d_rdata[g]),
      .mem_en_o   (mem_en[g]),
      .mem_we_o   (mem_we[g]),
      .mem_addr_o (mem_addr[g]),
      .mem_wdata_o(mem_wdata[g]),
      .mem_be_o   (mem_be[g]),
      .mem_rdata_i(mem_rdata)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step();
  endtask

  initial begin
    int unsigned lat;
    logic [15:0] c0;

    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 32'h4; d_addr = 32'h8; d_wdata = 32'hFFFF_FFFF; d_be = 4'hF;
    use_fixed = 1'b1; fixed_val = 32'hDEAD_BEEF;
    #3;
    check("rst_if_gnt", if_gnt[0], 0);
    check("rst_d_gnt", d_gnt[0], 0);
    check("rst_mem_en", mem_en[0], 0);
    check("rst_mem_addr", mem_addr[0], 0);
    check("rst_if_rvalid", if_rvalid[0], 0);
    check("rst_d_rdata", d_rdata[0], 0);
    step();
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    idle(2);

    // Single fetch, MEM_LAT=1
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    check("f1_if_gnt_T", if_gnt[0], 1);
    check("f1_d_gnt_T", d_gnt[0], 0);
    check("f1_mem_en_T", mem_en[0], 1);
    check("f1_mem_we_T", mem_we[0], 0);
    check("f1_mem_addr_T", mem_addr[0], 32'h10);
    check("f1_mem_be_T", mem_be[0], 0);
    step(); if_req = 1'b0; #1;
    check("f1_if_gnt_T1", if_gnt[0], 0);
    check("f1_mem_en_T1", mem_en[0], 0);
    check("f1_if_rvalid_T1", if_rvalid[0], 0);
    step(); #1;
    check("f1_if_rvalid_T2", if_rvalid[0], 1);
    check("f1_if_rdata_T2", if_rdata[0], 32'hDEAD_BEEF);
    check("f1_d_rvalid_T2", d_rvalid[0], 0);
    step(); #1;
    check("f1_if_rvalid_T3", if_rvalid[0], 0);
    idle(12);

    // Store, MEM_LAT=1
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678; d_be = 4'hF;
    #1;
    check("st_d_gnt_T", d_gnt[0], 1);
    check("st_mem_en_T", mem_en[0], 1);
    check("st_mem_we_T", mem_we[0], 1);
    check("st_mem_addr_T", mem_addr[0], 32'h20);
    check("st_mem_wdata_T", mem_wdata[0], 32'h1234_5678);
    check("st_mem_be_T", mem_be[0], 4'hF);
    step(); d_req = 1'b0; d_we = 1'b0; #1;
    check("st_d_rvalid_T1", d_rvalid[0], 0);
    step(); #1;
    check("st_d_rvalid_T2", d_rvalid[0], 1);
    check("st_d_rdata_T2", d_rdata[0], 0);
    check("st_if_rvalid_T2", if_rvalid[0], 0);
    check("st_if_rdata_hold", if_rdata[0], 32'hDEAD_BEEF);
    use_fixed = 1'b0;
    idle(12);

    // Continuous contention on MEM_LAT=2 right after reset
    rst = 1'b1; step(); rst = 1'b0; step();
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int unsigned i = 0; i < 13; i++) begin
      logic slot, slot_even, prev_even;
      #1;
      slot      = (i % 3 == 0);
      slot_even = ((i / 3) % 2 == 0);
      prev_even = (i >= 3) && (((i / 3) - 1) % 2 == 0);
      check($sformatf("rr_if_gnt_%0d", i), if_gnt[1], slot && slot_even);
      check($sformatf("rr_d_gnt_%0d", i), d_gnt[1], slot && !slot_even);
      check($sformatf("rr_if_rvalid_%0d", i), if_rvalid[1], slot && prev_even);
      check($sformatf("rr_d_rvalid_%0d", i), d_rvalid[1], slot && (i >= 3) && !prev_even);
      if (if_rvalid[1]) check($sformatf("rr_if_rdata_%0d", i), if_rdata[1], pat(cyc - 16'd1));
      if (d_rvalid[1])  check($sformatf("rr_d_rdata_%0d", i), d_rdata[1], pat(cyc - 16'd1));
      step();
    end
    if_req = 1'b0; d_req = 1'b0;
    idle(20);

    // Data request raised during fetch WAIT, MEM_LAT=1
    if_req = 1'b1; if_addr = 32'h30;
    #1;
    check("dw_if_gnt_T", if_gnt[0], 1);
    step(); if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; #1;
    check("dw_d_gnt_T1", d_gnt[0], 0);
    step(); #1;
    check("dw_if_rvalid_T2", if_rvalid[0], 1);
    check("dw_if_rdata_T2", if_rdata[0], pat(cyc - 16'd1));
    check("dw_d_gnt_T2", d_gnt[0], 1);
    check("dw_mem_addr_T2", mem_addr[0], 32'h40);
    step(); d_req = 1'b0; #1;
    check("dw_d_rvalid_T3", d_rvalid[0], 0);
    step(); #1;
    check("dw_d_rvalid_T4", d_rvalid[0], 1);
    check("dw_d_rdata_T4", d_rdata[0], pat(cyc - 16'd1));
    check("dw_if_rvalid_T4", if_rvalid[0], 0);
    idle(20);

    // Latency sweep: all four instances granted in the same cycle
    if_req = 1'b1; if_addr = 32'h50;
    #1;
    c0 = cyc;
    for (int unsigned g = 0; g < 4; g++) check($sformatf("sw_if_gnt_%0d", g), if_gnt[g], 1);
    step(); if_req = 1'b0;
    for (int unsigned i = 1; i <= 10; i++) begin
      #1;
      for (int unsigned g = 0; g < 4; g++) begin
        lat = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 8;
        check($sformatf("sw_if_rvalid_l%0d_t%0d", lat, i), if_rvalid[g], i == lat + 1);
        if (i == lat + 1)
          check($sformatf("sw_if_rdata_l%0d", lat), if_rdata[g], pat(c0 + 16'(lat)));
      end
      step();
    end
    idle(4);

    // Reset mid-WAIT on MEM_LAT=8, after a completed data access
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
    #1;
    check("rw_d_gnt_first", d_gnt[3], 1);
    step(); d_req = 1'b0;
    idle(12);
    check("rw_d_rdata_loaded", d_rdata[3] != 32'h0, 1);
    d_req = 1'b1;
    #1;
    check("rw_d_gnt_second", d_gnt[3], 1);
    step(); d_req = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    check("rw_rst_d_gnt", d_gnt[3], 0);
    check("rw_rst_mem_en", mem_en[3], 0);
    check("rw_rst_d_rvalid", d_rvalid[3], 0);
    check("rw_rst_d_rdata", d_rdata[3], 0);
    #4 rst = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      step();
      check($sformatf("rw_no_d_rvalid_%0d", i), d_rvalid[3], 0);
      check($sformatf("rw_no_if_rvalid_%0d", i), if_rvalid[3], 0);
    end
    if_req = 1'b1; d_req = 1'b1;
    #1;
    check("rw_tie_if_gnt", if_gnt[3], 1);
    check("rw_tie_d_gnt", d_gnt[3], 0);
    step(); if_req = 1'b0; d_req = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the CPU's single-ported unified memory between the instruction-fetch port and the load/store data port. It accepts one request per access slot, drives the memory for the granted requester, waits a parameterised fixed memory latency, then returns a registered response to the requester that owns the access. It sits between the fetch/LSU logic, which is driven by the decoded `mem_rd_o`/`mem_wr_o` controls, and the memory macro.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; must be a multiple of 8
- `MEM_LAT`, 1, memory read latency in cycles; legal range 1..8
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_i`  in  1  reset; asynchronous, active-high
- `if_req_i`  in  1  fetch request
- `if_addr_i`  in  ADDR_W  fetch address
- `if_gnt_o`  out  1  fetch granted this cycle (combinational)
- `if_rvalid_o`  out  1  fetch response valid (registered, one-cycle pulse)
- `if_rdata_o`  out  DATA_W  fetch read data (registered)
- `d_req_i`  in  1  data request
- `d_we_i`  in  1  1 = store, 0 = load
- `d_addr_i`  in  ADDR_W  data address
- `d_wdata_i`  in  DATA_W  store data
- `d_be_i`  in  DATA_W/8  store byte enables
- `d_gnt_o`  out  1  data granted this cycle (combinational)
- `d_rvalid_o`  out  1  data response valid; pulses for both loads and stores
- `d_rdata_o`  out  DATA_W  load data; 0 for stores
- `mem_en_o`, `mem_we_o`  out  1 each  memory enable and write strobe
- `mem_addr_o`, `mem_wdata_o`, `mem_be_o`  out  ADDR_W / DATA_W / DATA_W/8  memory command
- `mem_rdata_i`  in  DATA_W  memory read data, valid MEM_LAT cycles after the `mem_en_o` cycle

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- Arbitration happens only in IDLE or RESP ("slot open"). In WAIT, both grants are 0.
- Slot open with exactly one request pending: that requester is granted.
- Slot open with both requests pending: round-robin on the `last_d` register. Fetch wins if `last_d`=1; data wins otherwise. `last_d` resets to 1, so fetch wins the first tie.
- Grant cycle T:
  - `*_gnt_o`=1 and `mem_en_o`=1.
  - `mem_addr_o`, `mem_we_o`, `mem_wdata_o` and `mem_be_o` are muxed combinationally from the winner.
  - For fetch, `mem_we_o`=0, `mem_be_o`=0 and `mem_wdata_o`=0.
  - `last_d` updates to the winner (1 = data), and `owner` is latched.
  - The FSM goes to WAIT, loading a down-counter with MEM_LAT-1.
- WAIT:
  - `mem_en_o`=0 and all memory command outputs are 0.
  - The counter decrements each cycle. In the cycle where the counter reaches 0 (cycle T+MEM_LAT), `mem_rdata_i` is captured into the owner's rdata register, and the FSM goes to RESP.
  - For a store, the rdata register is written with 0.
- RESP:
  - The owner's `*_rvalid_o`=1 for exactly this cycle.
  - The slot is open, so a new grant in RESP goes to WAIT; with no request, the FSM goes to IDLE.
- Requesters hold `req` and their fields stable until the grant. Fields are sampled only in the grant cycle. Dropping `req` before the grant is legal and cancels the request.
- rdata registers hold their last value until overwritten. Only the rvalid pulse qualifies them.
- Counter width is clog2(8) = 3 bits. MEM_LAT outside 1..8 is unsupported.

## Timing
- Grant in cycle T means the response is visible (rvalid=1) in cycle T+MEM_LAT+1.
- Peak throughput is one access per MEM_LAT+1 cycles, including back-to-back grants issued from RESP.
- With MEM_LAT=1, the FSM goes IDLE→WAIT→RESP (grant at T, rvalid at T+2, next grant possible at T+2).
- Reset values: all outputs 0, state IDLE, counter 0, `last_d`=1, `owner`=fetch.
- Reset asserted mid-access: the FSM returns to IDLE immediately (asynchronous). The outstanding response is discarded and no rvalid is produced. The memory may complete the access internally; the arbiter ignores it.
- A request that arrives while the FSM is in WAIT waits with gnt=0 until the next open slot. There is no loss and no duplicate grant.
- `if_rvalid_o` and `d_rvalid_o` are never high in the same cycle. Neither grant is ever given more than once per slot.

## Test plan
- Single fetch, MEM_LAT=1, addr 0x10, memory returns 0xDEADBEEF: `if_gnt_o` is high at T; `if_rvalid_o` is high at T+2 with `if_rdata_o`=0xDEADBEEF; `d_rvalid_o` stays 0.
- Store, addr 0x20, wdata 0x12345678, be 0xF: at T, `mem_en_o`=`mem_we_o`=1 with those fields; `d_rvalid_o` pulses at T+MEM_LAT+1 with `d_rdata_o`=0.
- Both ports requesting continuously, MEM_LAT=2: grants alternate fetch, data, fetch, data, starting with fetch after reset, one grant every 3 cycles.
- Data request raised during fetch's WAIT: no grant until RESP; the data grant occurs in the same cycle as `if_rvalid_o`, and `d_rvalid_o` follows MEM_LAT+1 cycles later.
- Sweep MEM_LAT=1, 4, 8: rvalid arrives exactly MEM_LAT+1 cycles after the grant; the captured data matches `mem_rdata_i` at cycle T+MEM_LAT.
- Assert `rst_i` for half a cycle in WAIT: all outputs go to 0 immediately; no rvalid appears afterward; after release, the first tie is won by fetch.
